// File: rtl/smp8_pkg.sv
// Purpose: shared types and constants for the smp8 memory-response slave.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package smp8_pkg;

    // Data path width of the slave.
    localparam int DW = 8;

    // Memory-mapped I/O locations; every lower address goes to the RAM.
    localparam logic [7:0] PORT_IN_ADDR  = 8'hFE;
    localparam logic [7:0] PORT_OUT_ADDR = 8'hFF;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // True for addresses backed by the RAM (0x00-0xFD).
    function automatic logic is_ram_addr(input logic [7:0] a);
        return (a < PORT_IN_ADDR);
    endfunction

endpackage

// File: rtl/smp8_ram256.sv
// Purpose: 256x8 storage array, synchronous write, combinational read, no reset.
// Latency: write commits on the rising edge; read data follows addr_i combinationally.
// Backpressure: none, every write strobe is taken.
//
// Ports:
//   clk_i     clock
//   we_i      write strobe, sampled on the rising edge
//   addr_i    shared read/write address
//   wdata_i   write data
//   rdata_o   read data at addr_i
module smp8_ram256
    import smp8_pkg::*;
(
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [7:0]    addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    // Contents are deliberately left unreset so this maps onto plain RAM.
    logic [DW-1:0] mem_q [256];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/smp8_memresp.sv
// Purpose: single-outstanding memory slave: 256x8 RAM plus port_in (0xFE) / port_out (0xFF).
// Latency: rvalid is high in the cycle after WAIT_CYCLES wait states; one txn every WAIT_CYCLES+2 cycles.
// Backpressure: ready_o is high only in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   req_i, we_i           request strobe, 1=write / 0=read
//   addr_i, wdata_i       byte address and write data, latched on accept
//   ready_o, busy_o       IDLE indicator / WAIT-or-RESP indicator
//   rvalid_o, rdata_o     one-cycle completion pulse, response data (held until next response)
//   port_out_o, port_in_i memory-mapped output register and input port
module smp8_memresp
    import smp8_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          req_i,
    input  logic          we_i,
    input  logic [7:0]    addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          ready_o,
    output logic          rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic          busy_o,
    output logic [DW-1:0] port_out_o,
    input  logic [DW-1:0] port_in_i
);

    // Counter start value on entering WAIT; unused when there are no wait states.
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [7:0]    addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] port_out_q, port_out_d;

    logic          accept;
    logic          commit;
    logic          txn_we;
    logic [7:0]    txn_addr;
    logic [DW-1:0] txn_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    assign accept = req_i && (state_q == IDLE);

    // With zero wait states the commit edge is the accept edge itself, so the
    // latches are not yet loaded; take the live inputs in that case.
    assign txn_we    = (state_q == IDLE) ? we_i    : we_q;
    assign txn_addr  = (state_q == IDLE) ? addr_i  : addr_q;
    assign txn_wdata = (state_q == IDLE) ? wdata_i : wdata_q;

    // RESP is always entered from IDLE or WAIT, so this is the entry edge.
    assign commit = (state_d == RESP);
    assign ram_we = commit && txn_we && is_ram_addr(txn_addr);

    // ---------------------------------------------------------------
    // Sequencer: next state and wait counter
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Response data and output port update on the commit edge
    // ---------------------------------------------------------------
    always_comb begin
        rdata_d    = rdata_q;
        port_out_d = port_out_q;
        if (commit) begin
            if (txn_we) begin
                // A write answers with its own data, whatever the target.
                rdata_d = txn_wdata;
                if (txn_addr == PORT_OUT_ADDR) begin
                    port_out_d = txn_wdata;
                end
            end else if (txn_addr == PORT_OUT_ADDR) begin
                rdata_d = port_out_q;
            end else if (txn_addr == PORT_IN_ADDR) begin
                rdata_d = port_in_i;
            end else begin
                rdata_d = ram_rdata;
            end
        end
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rdata_q    <= '0;
            port_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            port_out_q <= port_out_d;
        end
    end

    // Request latches: frozen after accept so the initiator may change its
    // inputs freely while the transaction is in flight.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    smp8_ram256 u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .addr_i  (txn_addr),
        .wdata_i (txn_wdata),
        .rdata_o (ram_rdata)
    );

    assign ready_o    = (state_q == IDLE);
    assign busy_o     = (state_q == WAIT) || (state_q == RESP);
    assign rvalid_o   = (state_q == RESP);
    assign rdata_o    = rdata_q;
    assign port_out_o = port_out_q;

endmodule

// File: tb/tb_smp8_memresp.sv
// Purpose: scoreboard bench for smp8_memresp at WAIT_CYCLES = 2, 0 and 15.
// Latency: n/a.
// Backpressure: driver waits on ready before each request.
module tb_smp8_memresp;

    localparam int NI = 3;

    function automatic int unsigned wc_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 0 : 15);
    endfunction

    typedef struct {
        logic [7:0] rdata;
        bit         chk;
        logic [7:0] pout;
        int         acc_cyc;
    } exp_t;

    logic       clk;
    logic       rst   [NI];
    logic       req   [NI];
    logic       we    [NI];
    logic [7:0] addr  [NI];
    logic [7:0] wdata [NI];
    logic [7:0] pin   [NI];
    logic       rdy   [NI];
    logic       rvld  [NI];
    logic [7:0] rdat  [NI];
    logic       bsy   [NI];
    logic [7:0] pout  [NI];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: RAM image with written flags, port_out shadow.
    logic [7:0] mmem   [NI][256];
    bit         mval   [NI][256];
    logic [7:0] mpout  [NI];
    exp_t       sbq    [NI][$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d (W=%0d): got 0x%0h expected 0x%0h", name, g, wc_of(g), act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        smp8_memresp #(.WAIT_CYCLES(wc_of(g))) u_dut (
            .clk_i      (clk),
            .reset_i    (rst[g]),
            .req_i      (req[g]),
            .we_i       (we[g]),
            .addr_i     (addr[g]),
            .wdata_i    (wdata[g]),
            .ready_o    (rdy[g]),
            .rvalid_o   (rvld[g]),
            .rdata_o    (rdat[g]),
            .busy_o     (bsy[g]),
            .port_out_o (pout[g]),
            .port_in_i  (pin[g])
        );

        // Monitor: pops the scoreboard on each rvalid and measures busy/ready runs.
        int   run_busy = 0;
        int   run_nrdy = 0;
        exp_t e;
        always @(negedge clk) begin
            if (rst[g]) begin
                run_busy = 0;
                run_nrdy = 0;
            end else begin
                if (rvld[g]) begin
                    if (sbq[g].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_rvalid inst%0d: got rvalid=1 expected no pending transaction", g);
                    end else begin
                        e = sbq[g].pop_front();
                        if (e.chk) chk("rdata", g, 32'(rdat[g]), 32'(e.rdata));
                        chk("port_out", g, 32'(pout[g]), 32'(e.pout));
                        // rvalid is sampled high at the (W+1)-th edge after accept.
                        chk("rvalid_edges_after_accept", g, 32'(cyc - e.acc_cyc + 1), 32'(wc_of(g) + 1));
                    end
                end
                if (bsy[g]) run_busy++;
                if (!rdy[g]) run_nrdy++;
                if (!bsy[g] && run_busy > 0) begin
                    chk("busy_cycles", g, 32'(run_busy), 32'(wc_of(g) + 1));
                    chk("ready_low_cycles", g, 32'(run_nrdy), 32'(wc_of(g) + 1));
                    run_busy = 0;
                    run_nrdy = 0;
                end
            end
        end
    end

    // Issue one transaction; called and returns at a negedge.
    task automatic do_txn(input int g, input bit w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] pi, input bit push, input bit toggle, output int acc);
        int   n = 0;
        exp_t x;
        while (!rdy[g] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[g]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout inst%0d: got ready=0 for %0d cycles expected ready", g, n);
            acc = -1;
            return;
        end
        if (push) begin
            if (w) begin
                x.rdata = d;
                x.chk   = 1'b1;
                if (a == 8'hFF) mpout[g] = d;
                else if (a < 8'hFE) begin
                    mmem[g][a] = d;
                    mval[g][a] = 1'b1;
                end
            end else if (a == 8'hFF) begin
                x.rdata = mpout[g];
                x.chk   = 1'b1;
            end else if (a == 8'hFE) begin
                x.rdata = pi;
                x.chk   = 1'b1;
            end else begin
                x.rdata = mmem[g][a];
                x.chk   = mval[g][a];
            end
            x.pout    = mpout[g];
            x.acc_cyc = cyc + 1;
            sbq[g].push_back(x);
        end
        pin[g]   = pi;
        we[g]    = w;
        addr[g]  = a;
        wdata[g] = d;
        req[g]   = 1'b1;
        acc      = cyc + 1;
        @(negedge clk);
        if (toggle) begin
            n = 0;
            while (bsy[g] && n < 40) begin
                req[g]   = 1'b1;
                we[g]    = 1'($urandom);
                addr[g]  = 8'($urandom);
                wdata[g] = 8'($urandom);
                @(negedge clk);
                n++;
            end
        end
        req[g]   = 1'b0;
        we[g]    = 1'($urandom);
        addr[g]  = 8'($urandom);
        wdata[g] = 8'($urandom);
    endtask

    initial begin
        int         a1, a2, n;
        logic [7:0] ra;
        for (int g = 0; g < NI; g++) begin
            rst[g] = 1'b1; req[g] = 1'b0; we[g] = 1'b0;
            addr[g] = 8'h00; wdata[g] = 8'h00; pin[g] = 8'h00; mpout[g] = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("reset_ready", g, 32'(rdy[g]), 32'd1);
            chk("reset_busy", g, 32'(bsy[g]), 32'd0);
            chk("reset_rvalid", g, 32'(rvld[g]), 32'd0);
            chk("reset_rdata", g, 32'(rdat[g]), 32'h00);
            chk("reset_port_out", g, 32'(pout[g]), 32'h00);
            rst[g] = 1'b0;
        end

        // W=2: write/read RAM, back-to-back throughput.
        do_txn(0, 1'b1, 8'h00, 8'h37, 8'h00, 1'b1, 1'b0, a1);
        do_txn(0, 1'b0, 8'h00, 8'hC3, 8'h00, 1'b1, 1'b0, a2);
        chk("accept_interval", 0, 32'(a2 - a1), 32'(wc_of(0) + 2));
        // Port mapping.
        do_txn(0, 1'b1, 8'hFF, 8'hA5, 8'h00, 1'b1, 1'b0, a1);
        do_txn(0, 1'b0, 8'hFE, 8'h00, 8'h5A, 1'b1, 1'b0, a1);
        do_txn(0, 1'b1, 8'hFE, 8'h00, 8'h5A, 1'b1, 1'b0, a1);
        do_txn(0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, a1);
        // Inputs wiggled and req re-raised during WAIT.
        do_txn(0, 1'b1, 8'h10, 8'h77, 8'h00, 1'b1, 1'b1, a1);
        do_txn(0, 1'b0, 8'h10, 8'h00, 8'h00, 1'b1, 1'b1, a1);
        // Reset in the middle of WAIT.
        do_txn(0, 1'b1, 8'h20, 8'h11, 8'h00, 1'b1, 1'b0, a1);
        do_txn(0, 1'b1, 8'h20, 8'h99, 8'h00, 1'b0, 1'b0, a1);
        rst[0]   = 1'b1;
        mpout[0] = 8'h00;
        #1;
        chk("midwait_reset_ready", 0, 32'(rdy[0]), 32'd1);
        chk("midwait_reset_busy", 0, 32'(bsy[0]), 32'd0);
        chk("midwait_reset_rvalid", 0, 32'(rvld[0]), 32'd0);
        chk("midwait_reset_rdata", 0, 32'(rdat[0]), 32'h00);
        chk("midwait_reset_port_out", 0, 32'(pout[0]), 32'h00);
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        do_txn(0, 1'b0, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0, a1);
        do_txn(0, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, a1);

        // W=0: back-to-back every two cycles.
        do_txn(1, 1'b1, 8'h01, 8'h1D, 8'h00, 1'b1, 1'b0, a1);
        do_txn(1, 1'b0, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, a2);
        chk("accept_interval", 1, 32'(a2 - a1), 32'(wc_of(1) + 2));
        do_txn(1, 1'b1, 8'hFF, 8'h3C, 8'h00, 1'b1, 1'b0, a1);
        do_txn(1, 1'b0, 8'hFE, 8'h00, 8'h96, 1'b1, 1'b0, a2);
        chk("accept_interval", 1, 32'(a2 - a1), 32'(wc_of(1) + 2));

        // W=15: long wait.
        do_txn(2, 1'b1, 8'h03, 8'h5C, 8'h00, 1'b1, 1'b0, a1);
        do_txn(2, 1'b0, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1, a1);

        // Randomized traffic on every instance.
        for (int g = 0; g < NI; g++) begin
            repeat ((g == 2) ? 12 : 40) begin
                n = $urandom_range(0, 9);
                if (n == 0) ra = 8'hFE;
                else if (n == 1) ra = 8'hFF;
                else if (n == 2) ra = 8'h10;
                else ra = 8'($urandom_range(0, 7));
                do_txn(g, 1'($urandom), ra, 8'($urandom), 8'($urandom), 1'b1,
                       ($urandom_range(0, 3) == 0), a1);
            end
        end

        // Drain.
        n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            chk("pending_at_end", g, 32'(sbq[g].size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 time units expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
